// File: rtl/frost32_mem_arbiter_pkg.sv
// Shared types for the FROST32 memory-port arbiter: access encodings seen on the
// external port and the arbiter state enumeration.
`ifndef MSB_POS__FROST32_MEM_ARB_STATE
`define MSB_POS__FROST32_MEM_ARB_STATE 1
`endif

package frost32_mem_arbiter_pkg;

    typedef enum logic {
        DIAT_READ  = 1'b0,
        DIAT_WRITE = 1'b1
    } data_inout_access_type_e;

    typedef enum logic [1:0] {
        DIAS_32  = 2'd0,
        DIAS_16  = 2'd1,
        DIAS_8   = 2'd2,
        DIAS_BAD = 2'd3
    } data_inout_access_size_e;

    typedef enum logic [`MSB_POS__FROST32_MEM_ARB_STATE:0] {
        ST_ARB_IDLE,
        ST_ARB_FETCH,
        ST_ARB_DATA
    } arb_state_e;

endpackage

// File: rtl/frost32_mem_arbiter_if.sv
// External memory-access port: the arbiter is the master, the memory the slave.
interface frost32_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import frost32_mem_arbiter_pkg::*;

    logic                    mem_req;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    data_inout_access_type_e mem_access_type;
    data_inout_access_size_e mem_access_size;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_wait;

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_access_type, mem_access_size,
        input  mem_rdata, mem_wait
    );

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_access_type, mem_access_size,
        output mem_rdata, mem_wait
    );

endinterface

// File: rtl/frost32_mem_arbiter.sv
// Shares one external memory port between instruction fetch and load/store,
// data first, with a starvation counter that forces a fetch grant after a data burst.
module frost32_mem_arbiter
    import frost32_mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    fetch_req,
    input  logic [ADDR_WIDTH-1:0]   fetch_addr,
    output logic                    fetch_ack,
    output logic [DATA_WIDTH-1:0]   fetch_rdata,

    input  logic                    data_req,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    input  data_inout_access_type_e data_access_type,
    input  data_inout_access_size_e data_access_size,
    output logic                    data_ack,
    output logic                    data_err,
    output logic [DATA_WIDTH-1:0]   data_rdata,

    frost32_mem_arbiter_if.master   mem
);

    localparam int CNT_WIDTH = $clog2(MAX_DATA_BURST + 1);
    typedef logic [CNT_WIDTH-1:0] cnt_t;
    localparam cnt_t CNT_MAX = cnt_t'(MAX_DATA_BURST);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   wdata;
        data_inout_access_type_e access_type;
        data_inout_access_size_e access_size;
    } mem_arb_request_t;

    arb_state_e              state_q, state_d;
    cnt_t                    starve_cnt_q, starve_cnt_d;
    mem_arb_request_t        req_q, req_d;
    logic                    mem_req_q, mem_req_d;
    logic                    fetch_ack_q, fetch_ack_d;
    logic                    data_ack_q, data_ack_d;
    logic                    data_err_q, data_err_d;
    logic [DATA_WIDTH-1:0]   fetch_rdata_q, fetch_rdata_d;
    logic [DATA_WIDTH-1:0]   data_rdata_q, data_rdata_d;

    mem_arb_request_t        fetch_request, data_request;

    // Fetch is always a full-word read, so its store data is forced to zero.
    assign fetch_request = '{addr: fetch_addr, wdata: '0,
                             access_type: DIAT_READ, access_size: DIAS_32};
    assign data_request  = '{addr: data_addr, wdata: data_wdata,
                             access_type: data_access_type, access_size: data_access_size};

    always_comb begin
        // NOTE: every value written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        req_d         = req_q;
        mem_req_d     = mem_req_q;
        fetch_ack_d   = 1'b0;
        fetch_rdata_d = '0;
        data_ack_d    = 1'b0;
        data_err_d    = 1'b0;
        data_rdata_d  = '0;

        unique case (state_q)
            ST_ARB_IDLE: begin
                if (data_req && data_access_size == DIAS_BAD) begin
                    data_ack_d = 1'b1;
                    data_err_d = 1'b1;
                end else if (fetch_req && (!data_req || starve_cnt_q == CNT_MAX)) begin
                    state_d      = ST_ARB_FETCH;
                    req_d        = fetch_request;
                    mem_req_d    = 1'b1;
                    starve_cnt_d = '0;
                end else if (data_req) begin
                    state_d   = ST_ARB_DATA;
                    req_d     = data_request;
                    mem_req_d = 1'b1;
                    // Count is below CNT_MAX here, otherwise fetch would have won.
                    if (fetch_req) starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            ST_ARB_FETCH, ST_ARB_DATA: begin
                if (!mem.mem_wait) begin
                    state_d   = ST_ARB_IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == ST_ARB_FETCH) begin
                        fetch_ack_d   = 1'b1;
                        fetch_rdata_d = mem.mem_rdata;
                    end else begin
                        data_ack_d   = 1'b1;
                        data_rdata_d = (req_q.access_type == DIAT_WRITE) ? '0 : mem.mem_rdata;
                    end
                end
            end
            default: state_d = ST_ARB_IDLE;
        endcase

        if (!fetch_req) starve_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= ST_ARB_IDLE;
            starve_cnt_q  <= '0;
            req_q         <= '0;
            mem_req_q     <= 1'b0;
            fetch_ack_q   <= 1'b0;
            fetch_rdata_q <= '0;
            data_ack_q    <= 1'b0;
            data_err_q    <= 1'b0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            req_q         <= req_d;
            mem_req_q     <= mem_req_d;
            fetch_ack_q   <= fetch_ack_d;
            fetch_rdata_q <= fetch_rdata_d;
            data_ack_q    <= data_ack_d;
            data_err_q    <= data_err_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign mem.mem_req         = mem_req_q;
    assign mem.mem_addr        = req_q.addr;
    assign mem.mem_wdata       = req_q.wdata;
    assign mem.mem_access_type = req_q.access_type;
    assign mem.mem_access_size = req_q.access_size;

    assign fetch_ack   = fetch_ack_q;
    assign fetch_rdata = fetch_rdata_q;
    assign data_ack    = data_ack_q;
    assign data_err    = data_err_q;
    assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// Self-checking bench for frost32_mem_arbiter: directed scenarios with literal
// expectations, then random traffic checked every cycle against a transaction model.
module tb_frost32_mem_arbiter;
    import frost32_mem_arbiter_pkg::*;

    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset;
    logic                    fetch_req;
    logic [31:0]             fetch_addr;
    logic                    fetch_ack;
    logic [31:0]             fetch_rdata;
    logic                    data_req;
    logic [31:0]             data_addr;
    logic [31:0]             data_wdata;
    data_inout_access_type_e data_access_type;
    data_inout_access_size_e data_access_size;
    logic                    data_ack;
    logic                    data_err;
    logic [31:0]             data_rdata;

    frost32_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    frost32_mem_arbiter #(
        .MAX_DATA_BURST(MAX_BURST),
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_ack       (fetch_ack),
        .fetch_rdata     (fetch_rdata),
        .data_req        (data_req),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_access_type(data_access_type),
        .data_access_size(data_access_size),
        .data_ack        (data_ack),
        .data_err        (data_err),
        .data_rdata      (data_rdata),
        .mem             (mem_bus)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic        valid;
        logic        is_fetch;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } txn_t;

    typedef struct packed {
        logic        fack;
        logic        dack;
        logic        derr;
        logic [31:0] frd;
        logic [31:0] drd;
    } exp_t;

    txn_t cur   = '0;   // access currently on the bus
    exp_t expv  = '0;   // ack/data expected in the current cycle
    int   burst = 0;    // data grants in a row while fetch has been waiting

    always @(posedge clk) begin : ref_model
        txn_t n_cur;
        exp_t n_exp;
        int   n_burst;
        n_cur   = cur;
        n_burst = burst;
        n_exp   = '0;
        if (reset) begin
            n_cur   = '0;
            n_burst = 0;
        end else if (cur.valid) begin
            if (!mem_bus.mem_wait) begin
                if (cur.is_fetch) begin
                    n_exp.fack = 1'b1;
                    n_exp.frd  = mem_bus.mem_rdata;
                end else begin
                    n_exp.dack = 1'b1;
                    n_exp.drd  = cur.write ? 32'h0 : mem_bus.mem_rdata;
                end
                n_cur.valid = 1'b0;
            end
        end else if (data_req && data_access_size == DIAS_BAD) begin
            n_exp.dack = 1'b1;
            n_exp.derr = 1'b1;
        end else if (fetch_req && (!data_req || burst >= MAX_BURST)) begin
            n_cur   = '{valid: 1'b1, is_fetch: 1'b1, write: 1'b0,
                        addr: fetch_addr, wdata: 32'h0, size: 2'd0};
            n_burst = 0;
        end else if (data_req) begin
            n_cur = '{valid: 1'b1, is_fetch: 1'b0, write: (data_access_type == DIAT_WRITE),
                      addr: data_addr, wdata: data_wdata, size: 2'(data_access_size)};
            if (fetch_req) n_burst = (burst < MAX_BURST) ? burst + 1 : MAX_BURST;
        end
        if (!fetch_req) n_burst = 0;
        cur   <= n_cur;
        burst <= n_burst;
        expv  <= n_exp;
    end

    always @(negedge clk) begin : compare
        if (armed) begin
            check("mem_req",     32'(mem_bus.mem_req), 32'(cur.valid));
            check("fetch_ack",   32'(fetch_ack),       32'(expv.fack));
            check("fetch_rdata", fetch_rdata,          expv.frd);
            check("data_ack",    32'(data_ack),        32'(expv.dack));
            check("data_err",    32'(data_err),        32'(expv.derr));
            check("data_rdata",  data_rdata,           expv.drd);
            if (cur.valid) begin
                check("mem_addr",  mem_bus.mem_addr,               cur.addr);
                check("mem_wdata", mem_bus.mem_wdata,              cur.wdata);
                check("mem_type",  32'(mem_bus.mem_access_type),   32'(cur.write));
                check("mem_size",  32'(mem_bus.mem_access_size),   32'(cur.size));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic new_fetch();
        fetch_req  = 1'b1;
        fetch_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_data();
        data_req         = 1'b1;
        data_addr        = $urandom;
        data_wdata       = $urandom;
        data_access_type = data_inout_access_type_e'($urandom_range(0, 1));
        data_access_size = ($urandom_range(0, 7) == 0) ? DIAS_BAD
                         : data_inout_access_size_e'($urandom_range(0, 2));
    endtask

    task automatic rand_step();
        if (fetch_ack) begin
            if ($urandom_range(0, 3) != 0) new_fetch();
            else fetch_req = 1'b0;
        end else if (!fetch_req && $urandom_range(0, 2) == 0) begin
            new_fetch();
        end
        if (data_ack) begin
            if ($urandom_range(0, 7) != 0) new_data();
            else data_req = 1'b0;
        end else if (!data_req && $urandom_range(0, 1) == 0) begin
            new_data();
        end
        mem_bus.mem_wait  = ($urandom_range(0, 3) == 0);
        mem_bus.mem_rdata = $urandom;
    endtask

    initial begin
        reset             = 1'b1;
        fetch_req         = 1'b0;
        fetch_addr        = '0;
        data_req          = 1'b0;
        data_addr         = '0;
        data_wdata        = '0;
        data_access_type  = DIAT_READ;
        data_access_size  = DIAS_32;
        mem_bus.mem_wait  = 1'b0;
        mem_bus.mem_rdata = '0;

        repeat (2) @(negedge clk);
        armed = 1'b1;
        check("rst_mem_req",   32'(mem_bus.mem_req),         32'h0);
        check("rst_mem_addr",  mem_bus.mem_addr,             32'h0);
        check("rst_mem_type",  32'(mem_bus.mem_access_type), 32'h0);
        check("rst_mem_size",  32'(mem_bus.mem_access_size), 32'h0);
        check("rst_fetch_ack", 32'(fetch_ack),               32'h0);
        check("rst_data_ack",  32'(data_ack),                32'h0);
        check("rst_data_err",  32'(data_err),                32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single fetch, zero wait.
        fetch_req = 1'b1; fetch_addr = 32'h100; mem_bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("f1_mem_req",  32'(mem_bus.mem_req),         32'h1);
        check("f1_mem_addr", mem_bus.mem_addr,             32'h100);
        check("f1_mem_type", 32'(mem_bus.mem_access_type), 32'(DIAT_READ));
        check("f1_mem_size", 32'(mem_bus.mem_access_size), 32'(DIAS_32));
        @(negedge clk);
        check("f1_ack",   32'(fetch_ack), 32'h1);
        check("f1_rdata", fetch_rdata,    32'hDEADBEEF);
        fetch_req = 1'b0;
        @(negedge clk);
        check("f1_ack_low",   32'(fetch_ack),        32'h0);
        check("f1_rdata_low", fetch_rdata,           32'h0);
        check("f1_idle",      32'(mem_bus.mem_req),  32'h0);

        // Simultaneous fetch and 16-bit write: data goes first.
        fetch_req = 1'b1; fetch_addr = 32'h300;
        data_req = 1'b1; data_addr = 32'h200; data_wdata = 32'h12345678;
        data_access_type = DIAT_WRITE; data_access_size = DIAS_16;
        @(negedge clk);
        check("sim_mem_addr",  mem_bus.mem_addr,             32'h200);
        check("sim_mem_wdata", mem_bus.mem_wdata,            32'h12345678);
        check("sim_mem_type",  32'(mem_bus.mem_access_type), 32'(DIAT_WRITE));
        check("sim_mem_size",  32'(mem_bus.mem_access_size), 32'(DIAS_16));
        @(negedge clk);
        check("sim_data_ack",   32'(data_ack),  32'h1);
        check("sim_data_rdata", data_rdata,     32'h0);
        check("sim_fetch_wait", 32'(fetch_ack), 32'h0);
        data_req = 1'b0;
        @(negedge clk);
        check("sim_fetch_addr",  mem_bus.mem_addr,  32'h300);
        check("sim_fetch_wdata", mem_bus.mem_wdata, 32'h0);
        @(negedge clk);
        check("sim_fetch_ack", 32'(fetch_ack), 32'h1);
        fetch_req = 1'b0;
        @(negedge clk);

        // Data read with three wait cycles.
        data_req = 1'b1; data_addr = 32'h40; data_access_type = DIAT_READ;
        data_access_size = DIAS_32; mem_bus.mem_wait = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("ws_mem_req",  32'(mem_bus.mem_req), 32'h1);
            check("ws_mem_addr", mem_bus.mem_addr,     32'h40);
            check("ws_no_ack",   32'(data_ack),        32'h0);
        end
        mem_bus.mem_wait = 1'b0; mem_bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("ws_ack",   32'(data_ack),        32'h1);
        check("ws_rdata", data_rdata,           32'hCAFEF00D);
        check("ws_idle",  32'(mem_bus.mem_req), 32'h0);
        data_req = 1'b0;
        @(negedge clk);

        // Rejected access size.
        data_req = 1'b1; data_access_size = DIAS_BAD;
        @(negedge clk);
        check("bad_ack",     32'(data_ack),        32'h1);
        check("bad_err",     32'(data_err),        32'h1);
        check("bad_rdata",   data_rdata,           32'h0);
        check("bad_mem_req", 32'(mem_bus.mem_req), 32'h0);
        data_req = 1'b0;
        @(negedge clk);
        check("bad_ack_low", 32'(data_ack), 32'h0);
        check("bad_err_low", 32'(data_err), 32'h0);

        // Starvation: both held, every fifth grant must go to fetch.
        fetch_req = 1'b1; fetch_addr = 32'h500;
        data_req = 1'b1; data_addr = 32'h600; data_access_type = DIAT_READ;
        data_access_size = DIAS_32;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                check("starve_fetch_ack", 32'(fetch_ack), 32'((i / 2) % 5 == 0));
                check("starve_data_ack",  32'(data_ack),  32'((i / 2) % 5 != 0));
            end else begin
                check("starve_gap_fetch", 32'(fetch_ack), 32'h0);
                check("starve_gap_data",  32'(data_ack),  32'h0);
            end
        end
        fetch_req = 1'b0; data_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of a stalled data access.
        data_req = 1'b1; data_addr = 32'h80; mem_bus.mem_wait = 1'b1;
        @(negedge clk);
        check("rm_mem_req", 32'(mem_bus.mem_req), 32'h1);
        @(negedge clk);
        reset = 1'b1; data_req = 1'b0;
        @(negedge clk);
        check("rm_mem_req_low", 32'(mem_bus.mem_req), 32'h0);
        check("rm_fetch_ack",   32'(fetch_ack),       32'h0);
        check("rm_data_ack",    32'(data_ack),        32'h0);
        reset = 1'b0; mem_bus.mem_wait = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h104; mem_bus.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        check("rm_fetch_addr", mem_bus.mem_addr, 32'h104);
        @(negedge clk);
        check("rm_fetch_ack2",  32'(fetch_ack), 32'h1);
        check("rm_fetch_rdata", fetch_rdata,    32'h0BADF00D);
        fetch_req = 1'b0;
        @(negedge clk);

        // Random traffic against the model.
        repeat (4000) begin
            @(negedge clk);
            rand_step();
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
